// File: rtl/note_lane_scroller.sv
// Falling-note playfield: circular grid of note rows that scrolls downward on tick,
// with per-lane hit detection in the bottom window, score/combo tracking and a read port.
module note_lane_scroller #(
    parameter int unsigned LANES    = 5,
    parameter int unsigned ROWS     = 20,
    parameter int unsigned HIT_ROWS = 2,
    parameter int unsigned HIT_PTS  = 10,
    parameter int unsigned SCORE_W  = 16
) (
    input  logic                     vgaclk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     scroll_tick,
    input  logic [LANES-1:0]         new_row,
    input  logic [LANES-1:0]         btn,
    input  logic [$clog2(ROWS)-1:0]  rd_row,
    output logic [LANES-1:0]         rd_lanes,
    output logic [LANES-1:0]         hit_pulse,
    output logic                     miss_pulse,
    output logic [SCORE_W-1:0]       score,
    output logic [7:0]               combo
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam logic [RW:0] ROWS_W = (RW+1)'(ROWS);
    localparam int unsigned SUM_W = SCORE_W + 36;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [LANES-1:0]   grid_q [ROWS];
    logic [LANES-1:0]   grid_d [ROWS];
    logic [RW-1:0]      head_q, head_d;
    logic [LANES-1:0]   btn_prev_q;
    logic [LANES-1:0]   rd_lanes_q, rd_lanes_d;
    logic [LANES-1:0]   hit_q, hit_d;
    logic               miss_q, miss_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         combo_q, combo_d;

    logic [LANES-1:0]   press;
    logic [3:0]         nhits;
    logic               found;
    logic [RW-1:0]      phys;
    logic [RW-1:0]      bot;
    logic [SUM_W-1:0]   score_sum;
    logic [8:0]         combo_sum;

    // Logical row r lives at physical (head + r) mod ROWS.
    function automatic logic [RW-1:0] phys_of(input logic [RW-1:0] head,
                                              input logic [RW-1:0] r);
        logic [RW:0] sum;
        sum = {1'b0, head} + {1'b0, r};
        if (sum >= ROWS_W) sum = sum - ROWS_W;
        return sum[RW-1:0];
    endfunction

    always_comb begin
        press      = btn & ~btn_prev_q;
        grid_d     = grid_q;
        head_d     = head_q;
        hit_d      = '0;
        miss_d     = 1'b0;
        found      = 1'b0;
        phys       = '0;
        bot        = '0;
        nhits      = '0;

        if (run) begin
            // Presses act on the pre-scroll grid, lowest note in the window first.
            for (int l = 0; l < int'(LANES); l++) begin
                if (press[l]) begin
                    found = 1'b0;
                    for (int k = 0; k < int'(HIT_ROWS); k++) begin
                        phys = phys_of(head_q, RW'(ROWS - 1 - k));
                        if (!found && grid_d[phys][l]) begin
                            grid_d[phys][l] = 1'b0;
                            found = 1'b1;
                        end
                    end
                    if (found) hit_d[l] = 1'b1;
                    else       miss_d   = 1'b1;
                end
            end

            // The old bottom row becomes the new head and receives new_row.
            if (scroll_tick) begin
                bot = phys_of(head_q, RW'(ROWS - 1));
                if (|grid_d[bot]) miss_d = 1'b1;
                grid_d[bot] = new_row;
                head_d      = bot;
            end
        end

        for (int l = 0; l < int'(LANES); l++) begin
            nhits = nhits + 4'(hit_d[l]);
        end

        score_sum = SUM_W'(score_q) + SUM_W'(nhits) * SUM_W'(HIT_PTS);
        if (score_sum > SUM_W'(SCORE_MAX)) score_d = SCORE_MAX;
        else                               score_d = score_sum[SCORE_W-1:0];

        combo_sum = {1'b0, combo_q} + 9'(nhits);
        if (miss_d)                   combo_d = 8'd0;
        else if (combo_sum > 9'd255)  combo_d = 8'd255;
        else                          combo_d = combo_sum[7:0];

        if ({1'b0, rd_row} < ROWS_W) rd_lanes_d = grid_q[phys_of(head_q, rd_row)];
        else                         rd_lanes_d = '0;
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            grid_q     <= '{default: '0};
            head_q     <= '0;
            btn_prev_q <= '1;
            rd_lanes_q <= '0;
            hit_q      <= '0;
            miss_q     <= 1'b0;
            score_q    <= '0;
            combo_q    <= '0;
        end else begin
            grid_q     <= grid_d;
            head_q     <= head_d;
            btn_prev_q <= btn;
            rd_lanes_q <= rd_lanes_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
        end
    end

    assign rd_lanes   = rd_lanes_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign combo      = combo_q;

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed self-checking bench for note_lane_scroller at default parameters.
module tb_note_lane_scroller;

    logic       vgaclk = 1'b0;
    logic       reset;
    logic       run;
    logic       scroll_tick;
    logic [4:0] new_row;
    logic [4:0] btn;
    logic [4:0] rd_row;
    logic [4:0] rd_lanes;
    logic [4:0] hit_pulse;
    logic       miss_pulse;
    logic [15:0] score;
    logic [7:0] combo;

    int passed = 0;
    int total  = 0;

    note_lane_scroller dut (
        .vgaclk      (vgaclk),
        .reset       (reset),
        .run         (run),
        .scroll_tick (scroll_tick),
        .new_row     (new_row),
        .btn         (btn),
        .rd_row      (rd_row),
        .rd_lanes    (rd_lanes),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .score       (score),
        .combo       (combo)
    );

    always #5 vgaclk = ~vgaclk;

    task automatic cyc();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] pat(input int i);
        return 5'((i * 7 + 3) % 31 + 1);
    endfunction

    task automatic ticks(input int n, input logic [4:0] row);
        scroll_tick = 1'b1;
        new_row     = row;
        for (int i = 0; i < n; i++) cyc();
        scroll_tick = 1'b0;
        new_row     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; scroll_tick = 1'b0; new_row = '0; btn = '0; rd_row = '0;
        do_reset();
        chk("rst_rd", rd_lanes, 0);
        chk("rst_hit", hit_pulse, 0);
        chk("rst_miss", miss_pulse, 0);
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);

        // Single note travels to the bottom, then scrolls out.
        ticks(1, 5'b00001);
        ticks(19, 5'b00000);
        rd_row = 5'd19; cyc();
        chk("t1_row19", rd_lanes, 5'b00001);
        rd_row = 5'd18; cyc();
        chk("t1_row18", rd_lanes, 5'b00000);
        rd_row = 5'd20; cyc();
        chk("t1_oob", rd_lanes, 5'b00000);
        ticks(1, 5'b00000);
        chk("t1_miss", miss_pulse, 1);
        chk("t1_combo", combo, 0);
        chk("t1_hit", hit_pulse, 0);
        cyc();
        chk("t1_miss_1cyc", miss_pulse, 0);
        rd_row = 5'd19; cyc();
        chk("t1_empty", rd_lanes, 0);

        // Hit at row 18, then a wrong press.
        ticks(1, 5'b00001);
        ticks(18, 5'b00000);
        btn = 5'b00001; cyc();
        chk("t2_hit", hit_pulse, 5'b00001);
        chk("t2_score", score, 10);
        chk("t2_combo", combo, 1);
        chk("t2_miss", miss_pulse, 0);
        btn = 5'b00000; rd_row = 5'd18; cyc();
        chk("t2_hit_1cyc", hit_pulse, 0);
        cyc();
        chk("t2_cleared", rd_lanes, 0);
        btn = 5'b00001; cyc();
        chk("t2_wrong_miss", miss_pulse, 1);
        chk("t2_wrong_combo", combo, 0);
        chk("t2_wrong_score", score, 10);
        btn = 5'b00000; cyc();

        // Two lanes hit together with a scroll tick.
        ticks(1, 5'b01010);
        ticks(19, 5'b00000);
        btn = 5'b01010; scroll_tick = 1'b1; cyc();
        chk("t3_hit", hit_pulse, 5'b01010);
        chk("t3_score", score, 30);
        chk("t3_combo", combo, 2);
        chk("t3_miss", miss_pulse, 0);
        btn = 5'b00000; scroll_tick = 1'b0; cyc();

        // Hit plus scroll-out miss in the same cycle.
        ticks(1, 5'b10100);
        ticks(19, 5'b00000);
        btn = 5'b00100; scroll_tick = 1'b1; cyc();
        chk("t4_hit", hit_pulse, 5'b00100);
        chk("t4_miss", miss_pulse, 1);
        chk("t4_combo", combo, 0);
        chk("t4_score", score, 40);
        btn = 5'b00000; scroll_tick = 1'b0; cyc();

        // Button held through reset gives no press.
        btn = 5'b00001;
        do_reset();
        cyc();
        chk("t5_held_hit", hit_pulse, 0);
        chk("t5_held_miss", miss_pulse, 0);
        chk("t5_score", score, 0);
        btn = 5'b00000; cyc();
        btn = 5'b00001; cyc();
        chk("t5_repress_miss", miss_pulse, 1);
        btn = 5'b00000; cyc();

        // Wrap: 45 distinct rows, read back all 20.
        scroll_tick = 1'b1;
        for (int i = 0; i < 45; i++) begin
            new_row = pat(i);
            cyc();
        end
        scroll_tick = 1'b0; new_row = '0;
        for (int r = 0; r < 20; r++) begin
            rd_row = 5'(r);
            cyc();
            chk($sformatf("t6_row%0d", r), rd_lanes, pat(44 - r));
        end

        // Freeze: ticks and presses ignored, btn history still tracked.
        run = 1'b0; scroll_tick = 1'b1; new_row = 5'b11111;
        btn = 5'b11111; cyc();
        chk("t7_frz_hit", hit_pulse, 0);
        chk("t7_frz_miss", miss_pulse, 0);
        btn = 5'b00000; cyc();
        btn = 5'b11111; cyc();
        chk("t7_frz_hit2", hit_pulse, 0);
        run = 1'b1; scroll_tick = 1'b0; new_row = '0;
        cyc();
        chk("t7_no_edge_hit", hit_pulse, 0);
        chk("t7_no_edge_miss", miss_pulse, 0);
        chk("t7_score", score, 0);
        btn = 5'b00000;
        rd_row = 5'd0; cyc(); cyc();
        chk("t7_row0", rd_lanes, pat(44));
        rd_row = 5'd19; cyc();
        chk("t7_row19", rd_lanes, pat(25));

        // Saturation: full grid, 5 hits per press cycle.
        do_reset();
        ticks(20, 5'b11111);
        chk("t8_fill_miss", miss_pulse, 0);
        new_row = 5'b11111;
        btn = 5'b11111; scroll_tick = 1'b1; cyc();
        chk("t8_first_hit", hit_pulse, 5'b11111);
        chk("t8_first_score", score, 50);
        chk("t8_first_combo", combo, 5);
        btn = 5'b00000; scroll_tick = 1'b0; cyc();
        for (int n = 1; n < 1310; n++) begin
            btn = 5'b11111; scroll_tick = 1'b1; cyc();
            btn = 5'b00000; scroll_tick = 1'b0; cyc();
        end
        chk("t8_score_65500", score, 65500);
        chk("t8_combo_sat", combo, 255);
        btn = 5'b11111; scroll_tick = 1'b1; cyc();
        chk("t8_score_sat", score, 65535);
        chk("t8_sat_miss", miss_pulse, 0);
        btn = 5'b00000; scroll_tick = 1'b0; cyc();
        btn = 5'b11111; scroll_tick = 1'b1; cyc();
        chk("t8_score_hold", score, 65535);
        chk("t8_combo_hold", combo, 255);
        btn = 5'b00000; scroll_tick = 1'b0; cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
